// File: rtl/uart_pkg.sv
// Shared UART constants, the baud divisor layout and the reset-divisor calculation
// used by the baud tick generator.
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DIV_WIDTH          = 16;
  localparam int FRAC_BITS          = 4;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] int_part;
    logic [FRAC_BITS-1:0] frac;
  } baud_div_t;

  // round(clk_freq * 2^frac_bits / (baud * os))
  function automatic longint calc_div(input longint clk_freq, input longint baud,
                                      input longint os, input int frac_bits = FRAC_BITS);
    longint den;
    den = baud * os;
    return ((clk_freq << frac_bits) + (den / 2)) / den;
  endfunction

endpackage

// File: rtl/os_phase_counter.sv
// Oversample phase counter: tracks the os phase within a bit and emits mid_tick and
// bit_tick coincident with the os_tick that closes the matching phase.
module os_phase_counter
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sync,
  input  logic os_adv,
  output logic mid_tick,
  output logic bit_tick
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] PH_MID  = PW'(OVERSAMPLE / 2 - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);

  logic [PW-1:0] phase;

  // os_adv is already suppressed by sync and by en low, so the ticks follow it directly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase    <= '0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
    end else begin
      mid_tick <= os_adv && (phase == PH_MID);
      bit_tick <= os_adv && (phase == PH_LAST);
      if (sync)
        phase <= '0;
      else if (os_adv)
        phase <= (phase == PH_LAST) ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// Fractional baud tick source: divides clk into os_tick periods of div_int or div_int+1
// cycles, with glitch-free divisor retuning and start-bit re-phasing via sync.
module baud_tick_generator #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = uart_pkg::OVERSAMPLE_DEFAULT,
  parameter int DIV_WIDTH    = uart_pkg::DIV_WIDTH,
  parameter int FRAC_BITS    = uart_pkg::FRAC_BITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           sync,
  input  logic                           div_wr,
  input  logic [DIV_WIDTH+FRAC_BITS-1:0] div_in,
  output logic                           div_pend,
  output logic                           os_tick,
  output logic                           mid_tick,
  output logic                           bit_tick
);

  localparam int DW = DIV_WIDTH + FRAC_BITS;
  localparam int FW = (FRAC_BITS > 0) ? FRAC_BITS : 1;
  localparam logic [DW-1:0] RESET_DIV =
    DW'(uart_pkg::calc_div(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE, FRAC_BITS));

  logic [DW-1:0]        div_act;
  logic [DW-1:0]        div_pnd;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_int;
  logic [DIV_WIDTH-1:0] last;
  logic [FW-1:0]        acc;
  logic [FW-1:0]        div_frac;
  logic [FW:0]          acc_sum;
  logic                 ext;
  logic                 centering;
  logic                 boundary;

  always_comb begin
    div_int = div_act[DW-1:FRAC_BITS];
    if (div_int < DIV_WIDTH'(2))
      div_int = DIV_WIDTH'(2);
    div_frac = (FRAC_BITS > 0) ? div_act[FW-1:0] : '0;
    last     = div_int - DIV_WIDTH'(1) + DIV_WIDTH'(ext);
    boundary = en && !sync && (cnt == last);
    acc_sum  = {1'b0, acc} + {1'b0, div_frac};
  end

  // After sync, fractional carries are held off until the mid-bit tick so the
  // start-bit centre lands exactly (OVERSAMPLE/2)*div_int cycles later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      acc       <= '0;
      ext       <= 1'b0;
      centering <= 1'b0;
      os_tick   <= 1'b0;
      div_act   <= RESET_DIV;
      div_pend  <= 1'b0;
    end else begin
      os_tick <= boundary;
      if (mid_tick)
        centering <= 1'b0;
      if (sync) begin
        cnt       <= '0;
        acc       <= '0;
        ext       <= 1'b0;
        centering <= 1'b1;
      end else if (boundary) begin
        cnt <= '0;
        if (centering) begin
          ext <= 1'b0;
        end else begin
          acc <= acc_sum[FW-1:0];
          ext <= acc_sum[FW];
        end
      end else if (en) begin
        cnt <= cnt + DIV_WIDTH'(1);
      end

      if (div_wr && (sync || !en)) begin
        div_act  <= div_in;
        div_pend <= 1'b0;
      end else if (div_wr) begin
        div_pend <= 1'b1;
        if (boundary && div_pend)
          div_act <= div_pnd;
      end else if (boundary && div_pend) begin
        div_act  <= div_pnd;
        div_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (div_wr)
      div_pnd <= div_in;
  end

  os_phase_counter #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_phase (
    .clk      (clk),
    .reset    (reset),
    .sync     (sync),
    .os_adv   (boundary),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

endmodule

// File: tb/tb_baud_tick_generator.sv
// Directed bench for baud_tick_generator: tick spacing, divisor retune, sync, enable
// hold, divisor clamp and reset behaviour.
module tb_baud_tick_generator;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        sync = 1'b0;
  logic        div_wr = 1'b0;
  logic [19:0] div_in = '0;
  logic        div_pend, os_tick, mid_tick, bit_tick;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int os_q[$];
  int mid_q[$];
  int bit_q[$];

  baud_tick_generator dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync     (sync),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .div_pend (div_pend),
    .os_tick  (os_tick),
    .mid_tick (mid_tick),
    .bit_tick (bit_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (os_tick)  os_q.push_back(cyc);
    if (mid_tick) mid_q.push_back(cyc);
    if (bit_tick) bit_q.push_back(cyc);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return os_q.size();
      1:       return mid_q.size();
      default: return bit_q.size();
    endcase
  endfunction

  // Wait until queue sel holds at least n entries, bounded to 20000 cycles.
  task automatic wait_q(input int sel, input int n, input string tag);
    int k;
    k = 0;
    while (qsize(sel) < n && k < 20000) begin
      tick();
      k++;
    end
    chk(tag, qsize(sel) >= n, 1);
  endtask

  initial begin
    baud_div_t d31, d50, d10, d00;
    int k0, n, b, m, t, base, r;
    d31 = '{int_part: 16'd3, frac: 4'd1};
    d50 = '{int_part: 16'd5, frac: 4'd0};
    d10 = '{int_part: 16'd1, frac: 4'd0};
    d00 = '{int_part: 16'd0, frac: 4'd0};

    // reset state
    tick();
    chk("rst_os", os_tick, 0);
    chk("rst_mid", mid_tick, 0);
    chk("rst_bit", bit_tick, 0);
    chk("rst_pend", div_pend, 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_no_ticks", os_q.size(), 0);

    // default divisor 651 + 1/16
    k0 = cyc;
    en = 1'b1;
    wait_q(0, 1, "w_os1");
    chk("first_latency", os_q[0] - k0, 651);
    wait_q(0, 2, "w_os2");
    chk("period_651", os_q[1] - os_q[0], 651);
    wait_q(0, 16, "w_os16");
    chk("mid_at_8th", mid_q[0], os_q[7]);
    chk("bit_at_16th", bit_q[0], os_q[15]);
    chk("bit_count_16", bit_q.size(), 1);
    wait_q(0, 17, "w_os17");
    chk("period_652", os_q[16] - os_q[15], 652);
    wait_q(0, 32, "w_os32");
    wait_q(2, 2, "w_bit2");
    chk("bit_period", bit_q[1] - bit_q[0], 10417);

    // retune mid-period: old period finishes, then 3-cycle periods
    repeat (100) tick();
    div_in = d31;
    div_wr = 1'b1;
    tick();
    div_wr = 1'b0;
    chk("pend_set", div_pend, 1);
    wait_q(0, 33, "w_os33");
    chk("old_period_kept", os_q[32] - os_q[31], 652);
    chk("pend_clear", div_pend, 0);
    wait_q(0, 34, "w_os34");
    chk("new_period", os_q[33] - os_q[32], 3);

    // 16 ticks of 3 + 1/16 span 49 cycles, bit_tick on the 16th
    b = bit_q.size();
    wait_q(2, b + 1, "w_bitA");
    n = os_q.size();
    chk("bit_with_os", bit_q[b], os_q[n-1]);
    wait_q(0, n + 16, "w_os_span");
    chk("span_49", os_q[n+15] - os_q[n-1], 49);
    wait_q(2, b + 2, "w_bitB");
    chk("bit_on_16th", bit_q[b+1], os_q[n+15]);

    // sync with simultaneous divisor write (int 5, frac 0)
    repeat (2) tick();
    div_in = d50;
    div_wr = 1'b1;
    sync   = 1'b1;
    m = mid_q.size();
    b = bit_q.size();
    tick();
    div_wr = 1'b0;
    sync   = 1'b0;
    base = cyc;
    chk("sync_pend_zero", div_pend, 0);
    chk("sync_no_tick", {os_tick, mid_tick, bit_tick}, 0);
    wait_q(1, m + 1, "w_mid_sync");
    chk("sync_mid_40", mid_q[m] - base, 40);
    wait_q(2, b + 1, "w_bit_sync");
    chk("sync_bit_80", bit_q[b] - base, 80);

    // enable held low for 100 cycles, two cycles into a 5-cycle period
    n = os_q.size();
    wait_q(0, n + 1, "w_os_hold");
    t = os_q[n];
    repeat (2) tick();
    en = 1'b0;
    repeat (100) tick();
    chk("hold_no_ticks", os_q.size(), n + 1);
    en = 1'b1;
    wait_q(0, n + 2, "w_os_resume");
    chk("hold_resume", os_q[n+1] - t, 105);

    // clamp: int 1 applied immediately while disabled
    tick();
    en = 1'b0;
    div_in = d10;
    div_wr = 1'b1;
    tick();
    div_wr = 1'b0;
    chk("wr_en_low_pend", div_pend, 0);
    en = 1'b1;
    n = os_q.size();
    wait_q(0, n + 2, "w_clamp1");
    chk("clamp_int1", os_q[n+1] - os_q[n], 2);
    div_in = d00;
    div_wr = 1'b1;
    tick();
    div_wr = 1'b0;
    chk("pend_int0", div_pend, 1);
    n = os_q.size();
    wait_q(0, n + 3, "w_clamp0");
    chk("clamp_int0", os_q[n+2] - os_q[n+1], 2);
    chk("pend_int0_clr", div_pend, 0);

    // reset while os_tick is high: ticks drop at once, divisor reverts
    n = os_q.size();
    wait_q(0, n + 1, "w_pre_rst");
    reset = 1'b0;
    #1;
    chk("rst_async_ticks", {os_tick, mid_tick, bit_tick}, 0);
    chk("rst_async_pend", div_pend, 0);
    tick();
    r = cyc;
    reset = 1'b1;
    n = os_q.size();
    wait_q(0, n + 1, "w_post_rst");
    chk("rst_div_revert", os_q[n] - r, 651);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
